// File: rtl/axi_read_addr_arbiter_if.sv
// AXI read channel bundle (AR + R) for one port of the read arbiter.
// IdWidth is 1 on the master-facing ports and 2 on the slave-facing port.
interface axi_read_addr_arbiter_if #(
    parameter int unsigned IdWidth = 1,
    parameter int unsigned BW      = 32
);
    logic [IdWidth-1:0] arid;
    logic [BW-1:0]      araddr;
    logic [3:0]         arlen;
    logic [1:0]         arsize;
    logic [1:0]         arburst;
    logic [1:0]         arlock;
    logic [3:0]         arcache;
    logic [2:0]         arprot;
    logic               arvalid;
    logic               arready;

    logic [IdWidth-1:0] rid;
    logic [BW-1:0]      rdata;
    logic [1:0]         rresp;
    logic               rlast;
    logic               rvalid;
    logic               rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_read_addr_arbiter.sv
// Two-master / one-slave AXI read interconnect: round-robin AR arbitration with ID tagging,
// R beats routed back by RID[1], per-master outstanding-burst limiting.
module axi_read_addr_arbiter #(
    parameter int unsigned BW      = 32,
    parameter int unsigned MAX_OUT = 4
) (
    input logic                    ACLK,
    input logic                    ARESETn,  // active-high despite the name
    axi_read_addr_arbiter_if.slave  m0,
    axi_read_addr_arbiter_if.slave  m1,
    axi_read_addr_arbiter_if.master s
);

    typedef enum logic [0:0] {StIdle, StAddr} state_e;

    localparam logic [3:0] MaxCnt = 4'(MAX_OUT);

    state_e     state_q;
    logic       grant_q;
    logic       last_grant_q;
    logic [3:0] out_cnt0_q;
    logic [3:0] out_cnt1_q;

    logic       in_addr;
    logic       elig0, elig1;
    logic       g_arvalid;
    logic       ar_hs;
    logic       r_last_hs;
    logic       inc0, inc1, dec0, dec1;

    logic          g_arid;
    logic [BW-1:0] g_araddr;
    logic [3:0]    g_arlen;
    logic [1:0]    g_arsize;
    logic [1:0]    g_arburst;
    logic [1:0]    g_arlock;
    logic [3:0]    g_arcache;
    logic [2:0]    g_arprot;

    assign in_addr   = (state_q == StAddr);
    assign elig0     = m0.arvalid && (out_cnt0_q < MaxCnt);
    assign elig1     = m1.arvalid && (out_cnt1_q < MaxCnt);
    assign g_arvalid = grant_q ? m1.arvalid : m0.arvalid;
    assign ar_hs     = in_addr && g_arvalid && s.arready;
    assign r_last_hs = s.rvalid && s.rready && s.rlast;

    assign inc0 = ar_hs && !grant_q;
    assign inc1 = ar_hs && grant_q;
    assign dec0 = r_last_hs && !s.rid[1];
    assign dec1 = r_last_hs && s.rid[1];

    // Payload is zero outside ADDR so nothing leaks onto the slave bus in IDLE or reset.
    always_comb begin
        g_arid    = 1'b0;
        g_araddr  = '0;
        g_arlen   = '0;
        g_arsize  = '0;
        g_arburst = '0;
        g_arlock  = '0;
        g_arcache = '0;
        g_arprot  = '0;
        if (in_addr) begin
            if (grant_q) begin
                g_arid    = m1.arid;
                g_araddr  = m1.araddr;
                g_arlen   = m1.arlen;
                g_arsize  = m1.arsize;
                g_arburst = m1.arburst;
                g_arlock  = m1.arlock;
                g_arcache = m1.arcache;
                g_arprot  = m1.arprot;
            end else begin
                g_arid    = m0.arid;
                g_araddr  = m0.araddr;
                g_arlen   = m0.arlen;
                g_arsize  = m0.arsize;
                g_arburst = m0.arburst;
                g_arlock  = m0.arlock;
                g_arcache = m0.arcache;
                g_arprot  = m0.arprot;
            end
        end
    end

    assign s.arid    = {in_addr & grant_q, g_arid};
    assign s.araddr  = g_araddr;
    assign s.arlen   = g_arlen;
    assign s.arsize  = g_arsize;
    assign s.arburst = g_arburst;
    assign s.arlock  = g_arlock;
    assign s.arcache = g_arcache;
    assign s.arprot  = g_arprot;
    assign s.arvalid = in_addr && g_arvalid;

    assign m0.arready = in_addr && !grant_q && s.arready;
    assign m1.arready = in_addr && grant_q && s.arready;

    assign s.rready  = s.rid[1] ? m1.rready : m0.rready;

    assign m0.rid    = s.rid[0];
    assign m0.rdata  = s.rdata;
    assign m0.rresp  = s.rresp;
    assign m0.rlast  = s.rlast;
    assign m0.rvalid = s.rvalid && !s.rid[1];

    assign m1.rid    = s.rid[0];
    assign m1.rdata  = s.rdata;
    assign m1.rresp  = s.rresp;
    assign m1.rlast  = s.rlast;
    assign m1.rvalid = s.rvalid && s.rid[1];

    // Simultaneous issue and retire cancel; a retire at zero is unsolicited and ignored.
    function automatic logic [3:0] cnt_next(input logic [3:0] cnt, input logic inc,
                                            input logic dec);
        logic [3:0] nxt;
        nxt = cnt;
        if (inc && !dec) begin
            nxt = cnt + 4'd1;
        end else if (dec && !inc && (cnt != 4'd0)) begin
            nxt = cnt - 4'd1;
        end
        return nxt;
    endfunction

    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            out_cnt0_q   <= 4'd0;
            out_cnt1_q   <= 4'd0;
        end else begin
            out_cnt0_q <= cnt_next(out_cnt0_q, inc0, dec0);
            out_cnt1_q <= cnt_next(out_cnt1_q, inc1, dec1);
            unique case (state_q)
                StIdle: begin
                    if (elig0 && elig1) begin
                        grant_q <= ~last_grant_q;
                        state_q <= StAddr;
                    end else if (elig0) begin
                        grant_q <= 1'b0;
                        state_q <= StAddr;
                    end else if (elig1) begin
                        grant_q <= 1'b1;
                        state_q <= StAddr;
                    end
                end
                StAddr: begin
                    if (ar_hs) begin
                        last_grant_q <= grant_q;
                        state_q      <= StIdle;
                    end else if (!g_arvalid) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
